// File: rtl/single_err_search_ctrl.sv
// -----------------------------------------------------------------------------
// single_err_search_ctrl
// Sequential single-error position search for the QR BCH decode path.
// Latches one syndrome per input handshake, walks candidate positions
// 0..NUM_POS-1 into the single-position syndrome checker, one per cycle,
// tracks how many candidates hit and reports found/position/multi downstream
// over a valid/ready handshake.
//
// Configuration macro:
//   SINGLE_ERR_SEARCH_EARLY_EXIT_EN  - stop scanning at the first checker hit
//                                      (variable latency, res_multi tied 0).
//                                      Undefined: every candidate is scanned.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   s_valid/s_ready   syndrome input handshake, s_in is the syndrome
//   chk_s, chk_pos    latched syndrome and candidate position to the checker
//   chk_flag          checker hit for the current candidate (combinational)
//   chk_pos_ret       position echoed by the checker on a hit
//   res_valid/ready   result handshake
//   res_found         exactly one candidate hit
//   res_pos           hit position (0 unless res_found)
//   res_multi         more than one candidate hit
// -----------------------------------------------------------------------------
module single_err_search_ctrl #(
    parameter int unsigned SW      = 36,
    parameter int unsigned PW      = 6,
    parameter int unsigned NUM_POS = 37
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic [SW-1:0] s_in,
    output logic          s_ready,
    output logic [SW-1:0] chk_s,
    output logic [PW-1:0] chk_pos,
    input  logic          chk_flag,
    input  logic [PW-1:0] chk_pos_ret,
    output logic          res_valid,
    output logic          res_found,
    output logic [PW-1:0] res_pos,
    output logic          res_multi,
    input  logic          res_ready
);

`ifdef SINGLE_ERR_SEARCH_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [PW-1:0] LAST_POS = PW'(NUM_POS - 1);
    localparam logic [1:0]    CNT_SAT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic          s_ready_q;
    logic [SW-1:0] chk_s_q;
    logic [PW-1:0] chk_pos_q;
    logic [1:0]    hit_cnt_q;
    logic [PW-1:0] hit_pos_q;
    logic          res_valid_q;
    logic          res_found_q;
    logic [PW-1:0] res_pos_q;
    logic          res_multi_q;

    // Hit bookkeeping including the candidate sampled this cycle, so the
    // last scan cycle's hit is already visible when the result is latched.
    logic [1:0]    hit_cnt_d;
    logic [PW-1:0] hit_pos_d;
    logic          scan_end_c;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        hit_pos_d  = hit_pos_q;
        scan_end_c = 1'b0;
        if (chk_flag) begin
            if (hit_cnt_q != CNT_SAT) begin
                hit_cnt_d = hit_cnt_q + 2'd1;
            end
            if (hit_cnt_q == 2'd0) begin
                hit_pos_d = chk_pos_ret;
            end
        end
        if ((chk_pos_q == LAST_POS) || (EARLY_EXIT && chk_flag)) begin
            scan_end_c = 1'b1;
        end
    end

    // Control FSM with registered handshake, checker and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_ready_q   <= 1'b1;
            chk_s_q     <= '0;
            chk_pos_q   <= '0;
            hit_cnt_q   <= '0;
            hit_pos_q   <= '0;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_pos_q   <= '0;
            res_multi_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        chk_s_q     <= s_in;
                        chk_pos_q   <= '0;
                        hit_cnt_q   <= '0;
                        hit_pos_q   <= '0;
                        res_found_q <= 1'b0;
                        res_pos_q   <= '0;
                        res_multi_q <= 1'b0;
                        s_ready_q   <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    hit_cnt_q <= hit_cnt_d;
                    hit_pos_q <= hit_pos_d;
                    if (scan_end_c) begin
                        res_valid_q <= 1'b1;
                        res_found_q <= (hit_cnt_d == 2'd1);
                        res_pos_q   <= (hit_cnt_d == 2'd1) ? hit_pos_d : '0;
                        res_multi_q <= EARLY_EXIT ? 1'b0 : (hit_cnt_d >= CNT_SAT);
                        state_q     <= DONE;
                    end else begin
                        chk_pos_q <= chk_pos_q + PW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign chk_s     = chk_s_q;
    assign chk_pos   = chk_pos_q;
    assign res_valid = res_valid_q;
    assign res_found = res_found_q;
    assign res_pos   = res_pos_q;
    assign res_multi = res_multi_q;

endmodule

// File: tb/tb_single_err_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_single_err_search_ctrl
// Bench for single_err_search_ctrl: a checker model that hits when chk_s
// equals the H-column of chk_pos (or when the position is forced), a table of
// directed vectors, hand-written backpressure/reset sequences and randomized
// searches compared against a hit-list reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_single_err_search_ctrl;

    localparam int SW = 36;
    localparam int PW = 6;
    localparam int NP = 37;

`ifdef SINGLE_ERR_SEARCH_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic [SW-1:0] s_in;
    logic          s_ready;
    logic [SW-1:0] chk_s;
    logic [PW-1:0] chk_pos;
    logic          chk_flag;
    logic [PW-1:0] chk_pos_ret;
    logic          res_valid;
    logic          res_found;
    logic [PW-1:0] res_pos;
    logic          res_multi;
    logic          res_ready;

    logic [SW-1:0] col [64];
    logic [63:0]   force_mask;

    int n_checks = 0;
    int n_pass   = 0;
    int max_pos  = 0;
    int stab_err = 0;

    always #5 clk = ~clk;

    single_err_search_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_in       (s_in),
        .s_ready    (s_ready),
        .chk_s      (chk_s),
        .chk_pos    (chk_pos),
        .chk_flag   (chk_flag),
        .chk_pos_ret(chk_pos_ret),
        .res_valid  (res_valid),
        .res_found  (res_found),
        .res_pos    (res_pos),
        .res_multi  (res_multi),
        .res_ready  (res_ready)
    );

    // Checker model: hit on H-column match or on a forced position.
    assign chk_flag    = (int'(chk_pos) < NP) &&
                         ((chk_s == col[chk_pos]) || force_mask[chk_pos]);
    assign chk_pos_ret = chk_flag ? chk_pos : '0;

    // Watch candidate range and syndrome stability while busy.
    logic          prev_busy = 1'b0;
    logic [SW-1:0] prev_s    = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (int'(chk_pos) > max_pos) max_pos = int'(chk_pos);
            if (prev_busy && !s_ready && chk_s != prev_s) stab_err++;
            prev_busy = !s_ready;
            prev_s    = chk_s;
        end else begin
            prev_busy = 1'b0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One full search; returns the observed result and latency (cycles from
    // the accept cycle up to the edge that raised res_valid, inclusive).
    task automatic do_search(input logic [SW-1:0] syn, input logic [63:0] mask,
                             input int hold, input bit poke,
                             output logic f, output logic [PW-1:0] p,
                             output logic m, output int lat);
        @(negedge clk);
        check("s_ready_idle", s_ready, 1);
        s_in = syn; force_mask = mask; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("accept_pos0", chk_pos, 0);
        check("accept_syn", chk_s, syn);
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        f = res_found; p = res_pos; m = res_multi;
        if (poke) begin
            s_valid = 1'b1;
            s_in    = col[9];
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_stable_%0d", i),
                  {res_valid, res_found, res_pos, res_multi, s_ready},
                  {1'b1, f, p, m, 1'b0});
            if (poke) check("hold_syn", chk_s, syn);
        end
        @(negedge clk);
        s_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("release_s_ready", s_ready, 1);
        check("release_res_valid", res_valid, 0);
    endtask

    typedef struct {
        string         name;
        logic [SW-1:0] syn;
        logic [63:0]   mask;
        logic          exp_found;
        logic [PW-1:0] exp_pos;
        logic          exp_multi;
        int            exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic          f, m;
        logic [PW-1:0] p;
        int            lat;
        logic [63:0]   m320, m036;

        for (int k = 0; k < 64; k++) col[k] = 36'(64'(k + 1) * 64'd1234567891);
        col[5] = 36'd4957289597;
        m320 = '0; m320[3] = 1'b1; m320[20] = 1'b1;
        m036 = '0; m036[0] = 1'b1; m036[36] = 1'b1;

        vecs.push_back('{"col5", 36'd4957289597, 64'd0, 1'b1, 6'd5, 1'b0, EE ? 7 : 38});
        vecs.push_back('{"zero_syn", 36'd0, 64'd0, 1'b0, 6'd0, 1'b0, 38});
        vecs.push_back('{"no_match", 36'h123456789, 64'd0, 1'b0, 6'd0, 1'b0, 38});
        vecs.push_back('{"pos3_20", 36'd0, m320, EE, EE ? 6'd3 : 6'd0, !EE, EE ? 5 : 38});
        vecs.push_back('{"last36", col[36], 64'd0, 1'b1, 6'd36, 1'b0, 38});
        vecs.push_back('{"first0", col[0], 64'd0, 1'b1, 6'd0, 1'b0, EE ? 2 : 38});
        vecs.push_back('{"pos0_36", 36'd0, m036, EE, 6'd0, !EE, EE ? 2 : 38});

        rst_n = 1'b0; s_valid = 1'b0; s_in = '0; res_ready = 1'b0; force_mask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_chk", {chk_s, chk_pos}, 0);
        check("rst_res", {res_valid, res_found, res_pos, res_multi}, 0);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            do_search(vecs[i].syn, vecs[i].mask, 1, 1'b0, f, p, m, lat);
            check({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
            check({vecs[i].name, "_found"}, f,   vecs[i].exp_found);
            check({vecs[i].name, "_pos"},   p,   vecs[i].exp_pos);
            check({vecs[i].name, "_multi"}, m,   vecs[i].exp_multi);
        end

        // Backpressure: 10 held cycles with a new syndrome poked into DONE
        do_search(col[7], 64'd0, 10, 1'b1, f, p, m, lat);
        check("bp_found", f, 1);
        check("bp_pos", p, 7);
        do_search(col[9], 64'd0, 0, 1'b0, f, p, m, lat);
        check("bp_next_pos", p, 9);
        check("bp_next_found", f, 1);

        // Reset in the middle of a scan
        @(negedge clk);
        s_in = 36'h123456789; force_mask = '0; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat = 0;
        while (chk_pos != 6'd12 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("reach_pos12", chk_pos, 12);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_chk", {chk_s, chk_pos}, 0);
        check("mid_rst_res", {res_valid, res_found, res_pos, res_multi}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_search(col[2], 64'd0, 0, 1'b0, f, p, m, lat);
        check("post_rst_pos", p, 2);
        check("post_rst_lat", lat, EE ? 4 : 38);

        // Randomized searches against a hit-list model
        for (int t = 0; t < 40; t++) begin
            logic [SW-1:0] syn;
            logic [63:0]   mask;
            int            hits[$];
            int            sel, e_lat;
            logic          e_f, e_m;
            logic [PW-1:0] e_p;
            sel  = int'($urandom_range(0, 2));
            mask = '0;
            syn  = {$urandom, $urandom} & 64'hF_FFFF_FFFF;
            if (sel == 0) syn = col[$urandom_range(0, NP - 1)];
            if (sel == 2) begin
                int nb;
                nb = int'($urandom_range(1, 3));
                for (int b = 0; b < nb; b++) mask[$urandom_range(0, NP - 1)] = 1'b1;
            end
            hits.delete();
            for (int k = 0; k < NP; k++)
                if (syn == col[k] || mask[k]) hits.push_back(k);
            if (EE) begin
                e_f   = hits.size() > 0;
                e_p   = e_f ? PW'(hits[0]) : '0;
                e_m   = 1'b0;
                e_lat = e_f ? hits[0] + 2 : NP + 1;
            end else begin
                e_f   = hits.size() == 1;
                e_p   = e_f ? PW'(hits[0]) : '0;
                e_m   = hits.size() > 1;
                e_lat = NP + 1;
            end
            do_search(syn, mask, int'($urandom_range(0, 3)), 1'b0, f, p, m, lat);
            check($sformatf("rnd%0d_lat", t),   lat, e_lat);
            check($sformatf("rnd%0d_found", t), f,   e_f);
            check($sformatf("rnd%0d_pos", t),   p,   e_p);
            check($sformatf("rnd%0d_multi", t), m,   e_m);
        end

        check("max_chk_pos", max_pos, NP - 1);
        check("chk_s_stable", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/single_err_search_ctrl.md
Name: single_err_search_ctrl

Overview:
- Sequential search controller that sits directly upstream of the single-position syndrome checker in the QR BCH decode path.
- Latches one 36-bit syndrome per handshake and steps the candidate error position 0..NUM_POS-1, presenting one candidate per cycle to the checker.
- Samples the checker's combinational hit flag and returns found/position to the downstream correction stage over a valid/ready handshake.

Parameters:
- SW, 36, syndrome width.
- PW, 6, position width.
- NUM_POS, 37, number of candidate positions; scanned 0..NUM_POS-1. Must satisfy NUM_POS <= 2^PW.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input syndrome valid.
- s_in  in  SW  syndrome to search.
- s_ready  out  1  controller can accept a syndrome.
- chk_s  out  SW  registered syndrome driven to the checker.
- chk_pos  out  PW  candidate position driven to the checker.
- chk_flag  in  1  checker hit, combinational from chk_s/chk_pos.
- chk_pos_ret  in  PW  position echoed by the checker; 0 when no hit.
- res_valid  out  1  result valid.
- res_found  out  1  exactly one accepted hit.
- res_pos  out  PW  error position; 0 when not found.
- res_multi  out  1  more than one candidate hit.
- res_ready  in  1  downstream accepts result.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - state=IDLE; s_ready=1.
  - chk_s=0; chk_pos=0.
  - res_valid=0; res_found=0; res_pos=0; res_multi=0.
  - Internal hit counter = 0.
- IDLE:
  - s_ready=1.
  - On s_valid: latch s_in into chk_s, chk_pos<=0, clear hit counter and result regs, go to SCAN.
- SCAN:
  - s_ready=0.
  - Each cycle, sample chk_flag for the current chk_pos.
  - On a hit: hit counter increments, saturating at 2. On the first hit only, res_pos<=chk_pos_ret.
  - If chk_pos==NUM_POS-1, or early exit applies (see Optional Feature), go to DONE.
  - Otherwise chk_pos<=chk_pos+1.
  - chk_pos never exceeds NUM_POS-1. There is no wrap.
- DONE:
  - res_valid=1.
  - res_found=1 when hit counter==1.
  - res_multi=1 when hit counter>=2; in that case res_found=0 and res_pos=0.
  - No hit: res_found=0, res_pos=0.
  - Outputs are held stable until res_ready.
  - When res_valid&res_ready: res_valid<=0, go to IDLE. s_ready returns to 1 the following cycle.
- Latency:
  - Full scan: accept cycle + NUM_POS SCAN cycles, with res_valid on the next edge, i.e. 38 cycles from s_valid accept to res_valid when NUM_POS=37.
  - Early exit at position k: k+1 SCAN cycles.
- Input handshake: s_valid while s_ready=0 is ignored. No input buffering.
- Backpressure: res_ready low holds DONE indefinitely. No new syndrome is accepted.
- Reset mid-scan or mid-DONE: immediate return to reset values. Any partial result is discarded.
- Stability: chk_s is held constant throughout SCAN and DONE.
- Zero syndrome: scanned normally. The result is whatever the checker reports.

Optional Feature:
- Macro: SINGLE_ERR_SEARCH_EARLY_EXIT_EN.
- Defined:
  - SCAN leaves to DONE in the cycle of the first chk_flag.
  - res_multi is tied to 0.
  - Latency varies with the hit position.
- Not defined:
  - All NUM_POS candidates are always scanned.
  - Latency is fixed.
  - Multiple hits are reported via res_multi.

Test Plan:
- Bench uses a checker model that hits at position k when chk_s equals H-column k (e.g. column 5 = 36'd4957289597). Stimulus: s_in=36'd4957289597. Required: res_found=1, res_pos=5, res_multi=0. Timing: res_valid 38 cycles after accept, or 7 cycles with EARLY_EXIT_EN.
- Syndrome matching no column (checker never flags) → after 38 cycles: res_valid=1, res_found=0, res_pos=0, res_multi=0.
- Checker model forced to flag positions 3 and 20, without the macro → res_multi=1, res_found=0, res_pos=0. With the macro → res_found=1, res_pos=3.
- Last position: hit at k=36 → res_pos=36; chk_pos is never seen above 36.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → outputs stable and s_ready=0; drive s_valid with a new syndrome during DONE → ignored. Raise res_ready → IDLE and s_ready=1 next cycle; the next syndrome is then processed correctly.
- Reset: assert rst_n=0 at SCAN position 12 → all outputs go to reset values asynchronously. After release, a new search runs from chk_pos=0.
